// File: rtl/rr_arbiter32_pkg.sv
// Shared constants and FSM state type for the 32-way round-robin arbiter.
package rr_arbiter32_pkg;
  localparam int NREQ  = 32;
  localparam int IDX_W = 5;

  // After reset, index 31 counts as the last winner, so index 0 goes first.
  localparam logic [IDX_W-1:0] LAST_IDX_RST = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2
  } arb_state_t;
endpackage

// File: rtl/lsb_first_encoder32.sv
// Combinational 32-to-5 priority encoder in which the lowest set index wins.
module lsb_first_encoder32
  import rr_arbiter32_pkg::*;
(
  input  logic [NREQ-1:0]  vec,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);
  always_comb begin
    idx = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = NREQ - 1; i >= 0; i--)
      if (vec[i]) idx = IDX_W'(i);
  end

  assign vld = |vec;
endmodule

// File: rtl/rr_arbiter32.sv
// Round-robin arbiter for 32 requesters: IDLE -> ARB -> GRANT with registered grant outputs.
// Define ARB_TIMEOUT_EN to revoke a grant after MAX_HOLD cycles.
module rr_arbiter32
  import rr_arbiter32_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             done,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             busy,
  output logic             timeout
);
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("MAX_HOLD must be at least 1");
  end

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] win_idx_q, win_idx_d;
  logic [IDX_W-1:0] last_idx_q, last_idx_d;
  logic [NREQ-1:0]  grant_d;
  logic [IDX_W-1:0] grant_idx_d;
  logic             grant_valid_d;

  logic [NREQ-1:0]  hi_mask, masked_req;
  logic [IDX_W-1:0] m_idx, u_idx, sel_idx;
  logic             m_vld, u_vld;
  logic             release_c, revoke;

  // Only bits strictly above the last winner; empty when last_idx is 31.
  assign hi_mask    = ~({NREQ{1'b1}} >> (IDX_W'(NREQ - 1) - last_idx_q));
  assign masked_req = req & hi_mask;

  lsb_first_encoder32 u_enc_masked (.vec(masked_req), .idx(m_idx), .vld(m_vld));
  lsb_first_encoder32 u_enc_all    (.vec(req),        .idx(u_idx), .vld(u_vld));

  assign sel_idx   = m_vld ? m_idx : u_idx;
  assign release_c = done | ~req[win_idx_q];
  assign busy      = (state_q != IDLE);

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_q;
  logic              timeout_q;

  // The counter is zero in the first GRANT cycle and counts each GRANT cycle after it.
  assign revoke = (state_q == GRANT) && (hold_q == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= (state_q == GRANT) ? hold_q + HOLD_W'(1) : '0;
      timeout_q <= revoke & ~release_c;
    end
  end

  assign timeout = timeout_q;
`else
  assign revoke  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      win_idx_q   <= '0;
      last_idx_q  <= LAST_IDX_RST;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_idx_q   <= win_idx_d;
      last_idx_q  <= last_idx_d;
      grant       <= grant_d;
      grant_idx   <= grant_idx_d;
      grant_valid <= grant_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    win_idx_d     = win_idx_q;
    last_idx_d    = last_idx_q;
    grant_d       = grant;
    grant_idx_d   = grant_idx;
    grant_valid_d = grant_valid;
    case (state_q)
      IDLE: begin
        if (u_vld) begin
          win_idx_d = sel_idx;
          state_d   = ARB;
        end
      end
      ARB: begin
        // A withdrawn request leaves the rotation pointer untouched.
        if (req[win_idx_q]) begin
          grant_d            = '0;
          grant_d[win_idx_q] = 1'b1;
          grant_idx_d        = win_idx_q;
          grant_valid_d      = 1'b1;
          state_d            = GRANT;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (release_c || revoke) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          last_idx_d    = win_idx_q;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_rr_arbiter32.sv
// Directed bench for rr_arbiter32: latency, rotation, withdrawal, reset mid-grant, hold limit.
module tb_rr_arbiter32;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] req = '0;
  logic        done = 1'b0;
  logic [31:0] grant;
  logic [4:0]  grant_idx;
  logic        grant_valid, busy, timeout;

  int checks = 0;
  int failures = 0;

  rr_arbiter32 #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid),
    .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_grant(input string tag, input int idx);
    logic [31:0] oh;
    oh = 32'h1 << idx;
    chk({tag, "_grant"}, grant, oh);
    chk({tag, "_idx"}, {27'd0, grant_idx}, idx);
    chk({tag, "_gv"}, {31'd0, grant_valid}, 32'd1);
  endtask

  // Release with done, then check the grant is gone in the following cycle.
  task automatic release_with_done(input string tag, input logic [31:0] next_req);
    done = 1'b1;
    step();
    done = 1'b0;
    req  = next_req;
    chk({tag, "_rel_gv"}, {31'd0, grant_valid}, 32'd0);
    chk({tag, "_rel_grant"}, grant, 32'd0);
  endtask

  int exp_seq [5] = '{0, 4, 31, 0, 4};

  initial begin
    // Reset state
    step();
    step();
    chk("rst_grant", grant, 32'd0);
    chk("rst_idx", {27'd0, grant_idx}, 32'd0);
    chk("rst_gv", {31'd0, grant_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_tmo", {31'd0, timeout}, 32'd0);

    // Single requester: grant from cycle 2, done at cycle 5, gone at cycle 6
    rst = 1'b0;
    req = 32'h1;
    step();
    chk("lat_c1_busy", {31'd0, busy}, 32'd1);
    chk("lat_c1_gv", {31'd0, grant_valid}, 32'd0);
    step();
    chk_grant("lat_c2", 0);
    step();
    step();
    step();
    chk_grant("lat_c5", 0);
    release_with_done("lat", 32'h0);
    chk("lat_c6_idx_hold", {27'd0, grant_idx}, 32'd0);

    // Rotation 0,4,31,0,4 with 3-cycle re-grant gap
    do_reset();
    req = 32'h8000_0011;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rot%0d_arb_gv", k), {31'd0, grant_valid}, 32'd0);
      step();
      chk_grant($sformatf("rot%0d", k), exp_seq[k]);
      release_with_done($sformatf("rot%0d", k), (k == 4) ? 32'h0 : req);
    end
    step();

    // One-cycle request pulse: ARB then back to IDLE, no grant, pointer unchanged
    do_reset();
    req = 32'h80;
    step();
    req = 32'h0;
    chk("pulse_arb_busy", {31'd0, busy}, 32'd1);
    chk("pulse_arb_gv", {31'd0, grant_valid}, 32'd0);
    step();
    chk("pulse_idle_busy", {31'd0, busy}, 32'd0);
    chk("pulse_idle_gv", {31'd0, grant_valid}, 32'd0);
    req = 32'h81;
    step();
    step();
    chk_grant("pulse_next", 0);
    release_with_done("pulse_next", 32'h0);
    // Pointer now at 0; a withdrawn bid by 7 must not move it to 7
    step();
    req = 32'h80;
    step();
    req = 32'h0;
    step();
    chk("pulse2_gv", {31'd0, grant_valid}, 32'd0);
    req = 32'h81;
    step();
    step();
    chk_grant("pulse2_next", 7);
    release_with_done("pulse2_next", 32'h0);
    step();

    // Reset during a grant to 3
    req = 32'h8;
    step();
    step();
    chk_grant("rstmid_pre", 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstmid_grant", grant, 32'd0);
    chk("rstmid_idx", {27'd0, grant_idx}, 32'd0);
    chk("rstmid_gv", {31'd0, grant_valid}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    step();
    chk("rstmid_c1_gv", {31'd0, grant_valid}, 32'd0);
    step();
    chk_grant("rstmid_regrant", 3);
    release_with_done("rstmid", 32'h0);
    step();

    // Hold limit with req=6 and no done
    do_reset();
    req = 32'h6;
    step();
    step();
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      chk_grant($sformatf("hold%0d", k), 1);
      chk($sformatf("hold%0d_tmo", k), {31'd0, timeout}, 32'd0);
      step();
    end
    chk("revoke_tmo", {31'd0, timeout}, 32'd1);
    chk("revoke_gv", {31'd0, grant_valid}, 32'd0);
    chk("revoke_grant", grant, 32'd0);
    step();
    chk("revoke_tmo_pulse", {31'd0, timeout}, 32'd0);
    chk("revoke_arb_gv", {31'd0, grant_valid}, 32'd0);
    step();
    chk_grant("revoke_next", 2);
`else
    for (int k = 0; k < 100; k++) begin
      chk($sformatf("hold%0d_idx", k), {27'd0, grant_idx}, 32'd1);
      chk($sformatf("hold%0d_gv", k), {31'd0, grant_valid}, 32'd1);
      chk($sformatf("hold%0d_tmo", k), {31'd0, timeout}, 32'd0);
      step();
    end
`endif

    // Dropping the owner's request releases without done
    req = 32'h0;
    step();
    chk("drop_gv", {31'd0, grant_valid}, 32'd0);
    chk("drop_grant", grant, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rr_arbiter32.md
Name: rr_arbiter32

Overview:
- Round-robin arbiter sharing one 32-way resource (e.g. a bus slot or datapath port) among 32 requesters.
- Winner selection uses a lowest-index-first 32-to-5 priority encode over a rotating mask, so the requester above the last winner gets first priority.
- Two-cycle request-to-grant latency, matching the team's pipelined encoder timing.
- Grant is held until the owner releases it.

Parameters:
- NREQ, 32, number of requesters; fixed at 32, and index width is 5.
- MAX_HOLD, 16, maximum grant cycles before forced revoke. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  32  level request per requester; held until granted or abandoned
- done  in  1  owner releases the grant this cycle
- grant  out  32  one-hot grant, registered
- grant_idx  out  5  index of the current owner, registered
- grant_valid  out  1  high while any grant is held
- busy  out  1  high in ARB or GRANT state
- timeout  out  1  one-cycle pulse on forced revoke; tied 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (synchronous, active-high), applied in the next cycle:
  - grant=0, grant_idx=0, grant_valid=0, busy=0, timeout=0.
  - state=IDLE, last_idx=31, so index 0 has top priority after reset.
  - Reset mid-grant drops the grant at the next edge, with no done needed.
- Winner selection:
  - masked = req & (bits with index > last_idx).
  - If masked != 0, winner = lowest set bit of masked; otherwise winner = lowest set bit of req.
- States:
  - IDLE: if req != 0, register winner into win_idx and go to ARB; otherwise stay.
  - ARB: busy=1. If req[win_idx]=1, go to GRANT; grant, grant_idx and grant_valid become visible next cycle. If the request was withdrawn, go back to IDLE with no grant and last_idx unchanged.
  - GRANT: grant[win_idx]=1 and grant_valid=1. Exit when done=1, or req[win_idx]=0, or (feature) the hold counter reaches MAX_HOLD.
    - On exit: grant outputs clear at the next edge, last_idx <= win_idx, state goes to IDLE.
- Latency: request first high in cycle 0 with the arbiter IDLE gives grant high from cycle 2.
- Back-to-back: at least one IDLE cycle between grants, so the re-grant gap is 3 cycles.
- Simultaneous events:
  - done and a withdrawn request in the same cycle count as a single release.
  - req changes in other bits during GRANT are ignored until IDLE.
- Wrap-around:
  - last_idx=31 makes the mask empty, so the unmasked encode is used.
  - A lone requester is re-granted repeatedly.
- Invariants: grant is always one-hot or zero; grant_idx holds its last value while grant_valid=0.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- With it defined:
  - A hold counter clears on GRANT entry and increments each GRANT cycle.
  - When it reaches MAX_HOLD with no release, the grant is revoked. timeout pulses 1 cycle, aligned with the cycle grant drops, and last_idx <= win_idx so others rotate ahead.
  - A revoked requester that keeps req high is re-arbitrated normally.
- Without it: no counter; the grant is held indefinitely until done or the request drops; timeout=0.

Decomposition:
- Shared package:
  - NREQ=32 and IDX_W=5.
  - State enum IDLE/ARB/GRANT, 2-bit encoding.
  - Reset value of last_idx (31).
- Sub-module lsb_first_encoder32: combinational 32-to-5 encoder plus valid, lowest index wins; instanced twice (masked and unmasked).
- The FSM, mask generation and hold counter live in rr_arbiter32.

Test Plan:
- Reset, then req=32'h0000_0001 at cycle 0:
  - grant=32'h1 and grant_idx=0 from cycle 2.
  - done at cycle 5 gives grant=0 at cycle 6.
- req=32'h8000_0011 held constant, done pulsed each grant:
  - grant_idx sequence 0, 4, 31, 0, 4.
  - grants 3 cycles apart after each done.
- req bit 7 pulsed for 1 cycle only: IDLE→ARB→IDLE with grant_valid never 1; last_idx unchanged, so a next req=32'h81 grants 0.
- During a grant to 3, raise rst: at the next edge all outputs are 0; after release, req=32'h8 grants 3 again with a 2-cycle latency.
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=32'h6, no done:
  - grant_idx=1 for 4 cycles, then timeout=1 for one cycle.
  - next grant_idx=2.
- Without ARB_TIMEOUT_EN, same stimulus: grant_idx=1 is held for 100 cycles and timeout stays 0.
